ama_riscv_perf_mon: RTL and testbench

//  Synthesisable run monitor and performance counter bank for the ama_riscv core.

---
 rtl/ama_riscv_perf_pkg.sv | 27 ++
 rtl/ama_riscv_perf_cnt.sv | 41 ++++
 rtl/ama_riscv_perf_mon.sv | 157 +++++++++++++++
 tb/tb_ama_riscv_perf_mon.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_perf_pkg.sv
// Shared types and constants for the ama_riscv run monitor / performance counter bank.
package ama_riscv_perf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } perf_state_e;

    // rd_sel map; counter selects equal the counter index inside the bank
    localparam logic [3:0] SEL_CYCLES  = 4'd0;
    localparam logic [3:0] SEL_INSTRET = 4'd1;
    localparam logic [3:0] SEL_STALL   = 4'd2;
    localparam logic [3:0] SEL_EVT0    = 4'd3;
    localparam logic [3:0] SEL_STATUS  = 4'd15;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE_BIT  = 3;
    localparam int STAT_OVF_LSB   = 4;

    function automatic logic is_terminal(input perf_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/ama_riscv_perf_cnt.sv
// One wrapping performance counter with a sticky overflow flag; clear beats increment.
module ama_riscv_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/ama_riscv_perf_mon.sv
// Run monitor: test-completion FSM (tohost / watchdog), counter bank and registered MMIO read port.
module ama_riscv_perf_mon
    import ama_riscv_perf_pkg::*;
#(
    parameter int              CNT_W       = 64,
    parameter int              N_EVT       = 4,
    parameter int              WDT_W       = 32,
    parameter longint unsigned WDT_LIMIT   = 5_000_000,
    parameter int              WDT_MODE    = 0,
    parameter logic [31:0]     TOHOST_PASS = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cnt_clear,
    input  logic             retire,
    input  logic             stall_id,
    input  logic [N_EVT-1:0] evt,
    input  logic             tohost_we,
    input  logic [31:0]      tohost_data,
    input  logic             rd_en,
    input  logic [3:0]       rd_sel,
    input  logic             rd_hi,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic [2:0]       state,
    output logic             done,
    output logic [30:0]      fail_id
);

    localparam int N_CNT = N_EVT + 3;
    localparam int HI_W  = CNT_W - 32;
    localparam logic [WDT_W-1:0] WDT_TRIP = WDT_W'(WDT_LIMIT - 1);

    perf_state_e      state_d, state_q;
    logic             done_d, done_q;
    logic [30:0]      fail_id_d, fail_id_q;
    logic [WDT_W-1:0] wdt_d, wdt_q;
    logic [HI_W-1:0]  snap_d, snap_q;
    logic [31:0]      rd_data_d, rd_data_q;
    logic             rd_valid_q;

    logic             run;
    logic             wdt_retire_clr;
    logic [N_CNT-1:0] cnt_inc;
    logic [N_CNT-1:0] cnt_ovf;
    logic [CNT_W-1:0] cnt_val [N_CNT];
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_hit;
    logic [31:0]      status_lo;

    assign run            = (state_q == ST_RUN);
    assign wdt_retire_clr = (WDT_MODE != 0) && retire;
    // Bank order: cycles, instret, stalls, then the generic events
    assign cnt_inc        = {evt & {N_EVT{run}}, run & stall_id, run & retire, run};

    for (genvar i = 0; i < N_CNT; i++) begin : gen_cnt
        ama_riscv_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start | cnt_clear),
            .inc   (cnt_inc[i]),
            .cnt   (cnt_val[i]),
            .ovf   (cnt_ovf[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        fail_id_d = fail_id_q;
        wdt_d     = wdt_q;
        if (start) begin
            state_d   = ST_RUN;
            wdt_d     = '0;
            fail_id_d = '0;
        end else if (run) begin
            wdt_d = wdt_retire_clr ? '0 : wdt_q + WDT_W'(1);
            // Only odd tohost values signal completion; even writes are test chatter
            if (tohost_we && tohost_data[0]) begin
                if (tohost_data == TOHOST_PASS) begin
                    state_d = ST_PASS;
                end else begin
                    state_d   = ST_FAIL;
                    fail_id_d = tohost_data[31:1];
                end
            end else if ((wdt_q == WDT_TRIP) && !wdt_retire_clr) begin
                state_d = ST_TIMEOUT;
            end
        end
        done_d = is_terminal(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            fail_id_q <= '0;
            wdt_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            fail_id_q <= fail_id_d;
            wdt_q     <= wdt_d;
        end
    end

    // rd_en has no back-pressure: every cycle it is high yields rd_valid with rd_data on the next cycle.
    always_comb begin
        sel_cnt = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            if (rd_sel == 4'(i)) begin
                sel_cnt = cnt_val[i];
                sel_hit = 1'b1;
            end
        end

        status_lo = '0;
        status_lo[STAT_STATE_LSB +: 3]   = state_q;
        status_lo[STAT_DONE_BIT]         = done_q;
        status_lo[STAT_OVF_LSB +: N_CNT] = cnt_ovf;

        rd_data_d = '0;
        snap_d    = snap_q;
        if (rd_en) begin
            if (rd_sel == SEL_STATUS) begin
                rd_data_d = rd_hi ? {1'b0, fail_id_q} : status_lo;
            end else if (sel_hit) begin
                if (rd_hi) begin
                    rd_data_d = 32'(snap_q);
                end else begin
                    rd_data_d = sel_cnt[31:0];
                    snap_d    = sel_cnt[CNT_W-1:32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign done     = done_q;
    assign fail_id  = fail_id_q;

endmodule

// File: tb/tb_ama_riscv_perf_mon.sv
// Bench for ama_riscv_perf_mon: three instances share stimulus (main, mode-0 and mode-1 watchdog).
module tb_ama_riscv_perf_mon;
    import ama_riscv_perf_pkg::*;

    localparam int N_EVT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, cnt_clear, retire, stall_id, tohost_we, rd_en, rd_hi;
    logic [N_EVT-1:0] evt;
    logic [31:0]      tohost_data;
    logic [3:0]       rd_sel;

    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [2:0]  state_a, state_b, state_c;
    logic        done_a, done_b, done_c;
    logic [30:0] fail_id_a, fail_id_b, fail_id_c;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    ama_riscv_perf_mon #(.CNT_W(33), .N_EVT(N_EVT), .WDT_W(32), .WDT_LIMIT(1000), .WDT_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_clear(cnt_clear), .retire(retire),
        .stall_id(stall_id), .evt(evt), .tohost_we(tohost_we), .tohost_data(tohost_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .state(state_a), .done(done_a), .fail_id(fail_id_a)
    );

    ama_riscv_perf_mon #(.CNT_W(33), .N_EVT(N_EVT), .WDT_W(32), .WDT_LIMIT(8), .WDT_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_clear(cnt_clear), .retire(retire),
        .stall_id(stall_id), .evt(evt), .tohost_we(tohost_we), .tohost_data(tohost_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .state(state_b), .done(done_b), .fail_id(fail_id_b)
    );

    ama_riscv_perf_mon #(.CNT_W(33), .N_EVT(N_EVT), .WDT_W(32), .WDT_LIMIT(8), .WDT_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .cnt_clear(cnt_clear), .retire(retire),
        .stall_id(stall_id), .evt(evt), .tohost_we(tohost_we), .tohost_data(tohost_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .state(state_c), .done(done_c), .fail_id(fail_id_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] sel, input logic hi, input logic [31:0] exp);
        rd_en  = 1'b1;
        rd_sel = sel;
        rd_hi  = hi;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        rd_en  = 1'b0;
        rd_sel = 4'd0;
        rd_hi  = 1'b0;
    endtask

    // Scoreboard: every rd_valid on the main instance retires the oldest expected read
    always @(negedge clk) begin
        string       t;
        logic [31:0] e;
        if (rd_valid_a) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                check(t, rd_data_a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cnt_clear = 1'b0; retire = 1'b0; stall_id = 1'b0;
        evt = '0; tohost_we = 1'b0; tohost_data = '0; rd_en = 1'b0; rd_sel = '0; rd_hi = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset values, IDLE does not count
        check("rst_state", 32'(state_a), 32'(ST_IDLE));
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_fail_id", 32'(fail_id_a), 32'd0);
        retire = 1'b1; stall_id = 1'b1;
        tick(3);
        retire = 1'b0; stall_id = 1'b0;
        check("idle_state", 32'(state_a), 32'(ST_IDLE));
        do_read("rst_cycles", SEL_CYCLES, 1'b0, 32'd0);
        do_read("idle_instret", SEL_INSTRET, 1'b0, 32'd0);
        do_read("rst_status", SEL_STATUS, 1'b0, 32'd0);
        do_read("rst_status_hi", SEL_STATUS, 1'b1, 32'd0);

        // Pass: 10 run cycles, retire every 2nd, then tohost pass
        pulse_start();
        check("pass_run", 32'(state_a), 32'(ST_RUN));
        for (int i = 0; i < 10; i++) begin
            retire   = (i % 2 == 1);
            stall_id = (i < 3);
            evt      = (i == 4) ? 4'b0101 : 4'b0000;
            @(negedge clk);
        end
        retire = 1'b0; stall_id = 1'b0; evt = '0;
        tohost_we = 1'b1; tohost_data = 32'h1;
        @(negedge clk);
        tohost_we = 1'b0; tohost_data = '0;
        check("pass_state", 32'(state_a), 32'(ST_PASS));
        check("pass_done", 32'(done_a), 32'd1);
        check("pass_b_timeout", 32'(state_b), 32'(ST_TIMEOUT));
        check("pass_c_pass", 32'(state_c), 32'(ST_PASS));
        for (int i = 0; i < 20; i++) begin
            retire   = 1'($urandom_range(0, 1));
            stall_id = 1'($urandom_range(0, 1));
            evt      = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        retire = 1'b0; stall_id = 1'b0; evt = '0;
        do_read("pass_cycles", SEL_CYCLES, 1'b0, 32'd11);
        do_read("pass_cycles_hi", SEL_CYCLES, 1'b1, 32'd0);
        do_read("pass_instret", SEL_INSTRET, 1'b0, 32'd5);
        do_read("pass_stall", SEL_STALL, 1'b0, 32'd3);
        do_read("pass_evt0", SEL_EVT0, 1'b0, 32'd1);
        do_read("pass_evt1", SEL_EVT0 + 4'd1, 1'b0, 32'd0);
        do_read("pass_evt2", SEL_EVT0 + 4'd2, 1'b0, 32'd1);
        do_read("pass_status", SEL_STATUS, 1'b0, 32'h0000_000A);
        do_read("unmapped_sel", 4'd9, 1'b0, 32'd0);
        check("pass_held", 32'(state_a), 32'(ST_PASS));

        // Fail: even tohost ignored, odd non-pass value fails
        pulse_start();
        tick(2);
        tohost_we = 1'b1; tohost_data = 32'h6;
        @(negedge clk);
        tohost_we = 1'b0; tohost_data = '0;
        check("fail_even_ignored", 32'(state_a), 32'(ST_RUN));
        tick(1);
        tohost_we = 1'b1; tohost_data = 32'h7;
        @(negedge clk);
        tohost_we = 1'b0; tohost_data = '0;
        check("fail_state", 32'(state_a), 32'(ST_FAIL));
        check("fail_id", 32'(fail_id_a), 32'd3);
        check("fail_done", 32'(done_a), 32'd1);
        do_read("fail_cycles", SEL_CYCLES, 1'b0, 32'd5);
        do_read("fail_status_hi", SEL_STATUS, 1'b1, 32'd3);
        do_read("fail_status", SEL_STATUS, 1'b0, 32'h0000_000B);

        // Watchdog, no retire: both limit-8 instances trip on the 8th run cycle
        pulse_start();
        tick(7);
        check("wdt0_pre", 32'(state_b), 32'(ST_RUN));
        tick(1);
        check("wdt0_trip", 32'(state_b), 32'(ST_TIMEOUT));
        check("wdt1_noretire_trip", 32'(state_c), 32'(ST_TIMEOUT));
        check("wdt_main_run", 32'(state_a), 32'(ST_RUN));

        // Watchdog mode 1: periodic retire keeps it alive, trips 8 cycles after retire stops
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            retire = (i % 5 == 4);
            @(negedge clk);
        end
        retire = 1'b0;
        check("wdt1_alive", 32'(state_c), 32'(ST_RUN));
        check("wdt0_ignores_retire", 32'(state_b), 32'(ST_TIMEOUT));
        tick(7);
        check("wdt1_pre", 32'(state_c), 32'(ST_RUN));
        tick(1);
        check("wdt1_trip", 32'(state_c), 32'(ST_TIMEOUT));

        // Wrap: cycles preloaded to all-ones wraps to 0 and sets ovf[0]
        pulse_start();
        force dut_a.gen_cnt[0].u_cnt.cnt_q = 33'h1_FFFF_FFFF;
        #1;
        release dut_a.gen_cnt[0].u_cnt.cnt_q;
        @(negedge clk);
        do_read("wrap_cycles", SEL_CYCLES, 1'b0, 32'd0);
        do_read("wrap_cycles_hi", SEL_CYCLES, 1'b1, 32'd0);
        do_read("wrap_status", SEL_STATUS, 1'b0, 32'h0000_0011);
        retire = 1'b1;
        tick(2);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0; retire = 1'b0;
        do_read("clr_cycles", SEL_CYCLES, 1'b0, 32'd0);
        do_read("clr_instret", SEL_INSTRET, 1'b0, 32'd0);
        do_read("clr_status", SEL_STATUS, 1'b0, 32'h0000_0001);

        // Tear-free read: low half snapshots the high half
        pulse_start();
        tick(2);
        force dut_a.gen_cnt[0].u_cnt.cnt_q = 33'h1_0000_0005;
        #1;
        release dut_a.gen_cnt[0].u_cnt.cnt_q;
        do_read("rd_lo", SEL_CYCLES, 1'b0, 32'h5);
        tick(3);
        do_read("rd_hi_snap", SEL_CYCLES, 1'b1, 32'h1);
        do_read("rd_lo_adv", SEL_CYCLES, 1'b0, 32'hA);
        tick(2);

        // Asynchronous reset mid-run
        check("prerst_run", 32'(state_a), 32'(ST_RUN));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_a), 32'(ST_IDLE));
        check("async_rst_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read("post_rst_cycles", SEL_CYCLES, 1'b0, 32'd0);
        do_read("post_rst_instret", SEL_INSTRET, 1'b0, 32'd0);
        do_read("post_rst_status", SEL_STATUS, 1'b0, 32'd0);

        // start outranks a coincident tohost pass
        pulse_start();
        tick(3);
        start = 1'b1; tohost_we = 1'b1; tohost_data = 32'h1;
        @(negedge clk);
        start = 1'b0; tohost_we = 1'b0; tohost_data = '0;
        check("prio_state", 32'(state_a), 32'(ST_RUN));
        do_read("prio_cycles", SEL_CYCLES, 1'b0, 32'd0);

        tick(3);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
